// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: state codes and default widths.
package la_pkg;

  localparam int LA_DATA_W = 8;
  localparam int LA_ADDR_W = 10;

  localparam logic [2:0] LA_ST_IDLE     = 3'd0;
  localparam logic [2:0] LA_ST_PRE_FILL = 3'd1;
  localparam logic [2:0] LA_ST_ARMED    = 3'd2;
  localparam logic [2:0] LA_ST_POST     = 3'd3;
  localparam logic [2:0] LA_ST_DONE     = 3'd4;

endpackage

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: streams LA samples into a circular RAM, keeping a pre-trigger window
// and a post-trigger tail, then holds DONE with the trigger address until acknowledged.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W,
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic              ACK,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic              TRIG_IN,
  input  logic [DATA_W-1:0] LA_DATA_IN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        STATE
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;       // remaining writes in PRE_FILL or POST
  logic [ADDR_W-1:0] post_lat;

  // NOTE: all state below updates with non-blocking assignments so every branch sees the
  // pre-edge values of wr_ptr/cnt, which is what makes TRIG_ADDR equal the address written now.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= LA_ST_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      post_lat  <= '0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_DATA  <= '0;
      TRIG_ADDR <= '0;
    end else begin
      MEM_WE <= 1'b0;
      case (state)
        LA_ST_IDLE: begin
          if (START && !ABORT) begin
            post_lat <= POST_CNT;
            cnt      <= PRE_CNT;
            wr_ptr   <= '0;
            state    <= (PRE_CNT == '0) ? LA_ST_ARMED : LA_ST_PRE_FILL;
          end
        end

        LA_ST_PRE_FILL, LA_ST_ARMED, LA_ST_POST: begin
          if (ABORT) begin
            state <= LA_ST_IDLE;
          end else begin
            MEM_WE   <= 1'b1;
            MEM_ADDR <= wr_ptr;
            MEM_DATA <= LA_DATA_IN;
            wr_ptr   <= wr_ptr + CNT_LAST;
            if (state == LA_ST_PRE_FILL) begin
              cnt <= cnt - CNT_LAST;
              if (cnt == CNT_LAST) state <= LA_ST_ARMED;
            end else if (state == LA_ST_ARMED) begin
              if (TRIG_IN) begin
                TRIG_ADDR <= wr_ptr;
                cnt       <= post_lat;
                state     <= (post_lat == '0) ? LA_ST_DONE : LA_ST_POST;
              end
            end else begin
              cnt <= cnt - CNT_LAST;
              if (cnt == CNT_LAST) state <= LA_ST_DONE;
            end
          end
        end

        LA_ST_DONE: begin
          if (ABORT || ACK) state <= LA_ST_IDLE;
        end

        default: state <= LA_ST_IDLE;
      endcase
    end
  end

  assign BUSY  = (state == LA_ST_PRE_FILL) || (state == LA_ST_ARMED) || (state == LA_ST_POST);
  assign DONE  = (state == LA_ST_DONE);
  assign STATE = state;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: default-width instance for most scenarios and a
// 16-entry instance for the address-wrap scenario.
module tb_la_capture_ctrl;

  logic       CLK;
  logic       nRESET;

  logic       a_start, a_abort, a_ack, a_trig;
  logic [9:0] a_pre, a_post;
  logic [7:0] a_data;
  logic       a_we, a_busy, a_done;
  logic [9:0] a_addr, a_trig_addr;
  logic [7:0] a_mdata;
  logic [2:0] a_state;

  logic       b_start, b_abort, b_ack, b_trig;
  logic [3:0] b_pre, b_post;
  logic [7:0] b_data;
  logic       b_we, b_busy, b_done;
  logic [3:0] b_addr, b_trig_addr;
  logic [7:0] b_mdata;
  logic [2:0] b_state;

  int checks = 0;
  int errors = 0;
  int we_cnt;

  la_capture_ctrl u_dut_a (
    .CLK(CLK), .nRESET(nRESET), .START(a_start), .ABORT(a_abort), .ACK(a_ack),
    .PRE_CNT(a_pre), .POST_CNT(a_post), .TRIG_IN(a_trig), .LA_DATA_IN(a_data),
    .MEM_WE(a_we), .MEM_ADDR(a_addr), .MEM_DATA(a_mdata), .TRIG_ADDR(a_trig_addr),
    .BUSY(a_busy), .DONE(a_done), .STATE(a_state)
  );

  la_capture_ctrl #(.DATA_W(8), .ADDR_W(4)) u_dut_b (
    .CLK(CLK), .nRESET(nRESET), .START(b_start), .ABORT(b_abort), .ACK(b_ack),
    .PRE_CNT(b_pre), .POST_CNT(b_post), .TRIG_IN(b_trig), .LA_DATA_IN(b_data),
    .MEM_WE(b_we), .MEM_ADDR(b_addr), .MEM_DATA(b_mdata), .TRIG_ADDR(b_trig_addr),
    .BUSY(b_busy), .DONE(b_done), .STATE(b_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRESET = 1'b0;
    a_start = 0; a_abort = 0; a_ack = 0; a_trig = 0; a_pre = '0; a_post = '0; a_data = '0;
    b_start = 0; b_abort = 0; b_ack = 0; b_trig = 0; b_pre = '0; b_post = '0; b_data = '0;
    #3;
    check("rst_state", 32'(a_state), 0);
    check("rst_we",    32'(a_we),    0);
    check("rst_done",  32'(a_done),  0);
    check("rst_busy",  32'(a_busy),  0);
    step();
    nRESET = 1'b1;

    // Reset asserted mid-POST
    a_start = 1; a_pre = 10'd1; a_post = 10'd5;
    step();
    a_start = 0;
    check("t1_prefill", 32'(a_state), 1);
    step();
    check("t1_armed", 32'(a_state), 2);
    a_trig = 1;
    step();
    a_trig = 0;
    check("t1_post", 32'(a_state), 3);
    check("t1_trig_addr", 32'(a_trig_addr), 1);
    step();
    check("t1_we_before", 32'(a_we), 1);
    #3 nRESET = 1'b0;
    #1;
    check("t1_async_state", 32'(a_state), 0);
    check("t1_async_we",    32'(a_we),    0);
    check("t1_async_done",  32'(a_done),  0);
    check("t1_async_taddr", 32'(a_trig_addr), 0);
    check("t1_async_addr",  32'(a_addr),  0);
    step();
    nRESET = 1'b1;
    step();
    check("t1_idle_after", 32'(a_state), 0);

    // PRE=4, POST=3, trigger on write #6
    a_start = 1; a_pre = 10'd4; a_post = 10'd3;
    step();
    a_start = 0;
    check("t2_prefill", 32'(a_state), 1);
    check("t2_no_we_on_start", 32'(a_we), 0);
    we_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      a_trig = (k == 6);
      a_data = 8'(k + 48);
      step();
      we_cnt += int'(a_we);
      check($sformatf("t2_addr%0d", k), 32'(a_addr), 32'(k - 1));
      check($sformatf("t2_data%0d", k), 32'(a_mdata), 32'(k + 48));
      if (k == 4) check("t2_armed", 32'(a_state), 2);
      if (k == 6) check("t2_post", 32'(a_state), 3);
    end
    a_trig = 0;
    check("t2_done_state", 32'(a_state), 4);
    check("t2_done", 32'(a_done), 1);
    a_start = 1;
    step();
    a_start = 0;
    we_cnt += int'(a_we);
    check("t2_we_count", 32'(we_cnt), 9);
    check("t2_start_in_done", 32'(a_state), 4);
    check("t2_trig_addr", 32'(a_trig_addr), 5);
    check("t2_busy_done", 32'(a_busy), 0);
    a_ack = 1;
    step();
    a_ack = 0;
    check("t2_ack_idle", 32'(a_state), 0);
    check("t2_ack_done", 32'(a_done), 0);
    check("t2_ack_taddr", 32'(a_trig_addr), 5);

    // Trigger during pre-fill is ignored
    a_start = 1; a_pre = 10'd4; a_post = 10'd2;
    step();
    a_start = 0;
    for (int k = 1; k <= 8; k++) begin
      a_trig = (k <= 3);
      step();
      check($sformatf("t3_we%0d", k), 32'(a_we), 1);
    end
    check("t3_armed", 32'(a_state), 2);
    check("t3_done", 32'(a_done), 0);
    check("t3_addr", 32'(a_addr), 7);
    check("t3_taddr", 32'(a_trig_addr), 5);

    // START while busy, then ABORT with TRIG_IN on the same edge
    a_start = 1; a_pre = 10'd0; a_post = 10'd0;
    step();
    a_start = 0;
    check("t6_start_busy_state", 32'(a_state), 2);
    check("t6_start_busy_addr", 32'(a_addr), 8);
    a_abort = 1; a_trig = 1;
    step();
    a_abort = 0; a_trig = 0;
    check("t6_abort_state", 32'(a_state), 0);
    check("t6_abort_we", 32'(a_we), 0);
    check("t6_abort_done", 32'(a_done), 0);
    check("t6_abort_taddr", 32'(a_trig_addr), 5);
    step();
    step();
    check("t6_stay_done", 32'(a_done), 0);
    check("t6_stay_idle", 32'(a_state), 0);

    // PRE=0, POST=0: single write at address 0
    a_start = 1; a_pre = 10'd0; a_post = 10'd0;
    step();
    a_start = 0;
    check("t5_armed", 32'(a_state), 2);
    check("t5_no_we", 32'(a_we), 0);
    a_trig = 1; a_data = 8'h5A;
    step();
    a_trig = 0;
    check("t5_we", 32'(a_we), 1);
    check("t5_addr", 32'(a_addr), 0);
    check("t5_data", 32'(a_mdata), 32'h5A);
    check("t5_taddr", 32'(a_trig_addr), 0);
    check("t5_done", 32'(a_done), 1);
    step();
    check("t5_we_off", 32'(a_we), 0);
    check("t5_done_hold", 32'(a_done), 1);
    a_ack = 1;
    step();
    a_ack = 0;
    check("t5_ack_idle", 32'(a_state), 0);

    // 16-entry RAM, PRE=2, trigger on write #20
    b_start = 1; b_pre = 4'd2; b_post = 4'd1;
    step();
    b_start = 0;
    for (int k = 1; k <= 21; k++) begin
      b_trig = (k == 20);
      b_data = 8'(k);
      step();
      check($sformatf("t4_addr%0d", k), 32'(b_addr), 32'((k - 1) % 16));
      if (k == 20) begin
        check("t4_taddr", 32'(b_trig_addr), 3);
        check("t4_post", 32'(b_state), 3);
      end
    end
    b_trig = 0;
    check("t4_done", 32'(b_done), 1);
    check("t4_taddr_hold", 32'(b_trig_addr), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
